// File: rtl/psp_retmon_pkg.sv
// Shared types for the PSP retire monitor: verdict state encoding and lane limits.
package psp_retmon_pkg;

    localparam int NRET_MAX = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } retmon_state_e;

endpackage

// File: rtl/psp_lane_prefix.sv
// Exclusive prefix popcount of the retire strobes: per-lane offsets plus the total.
module psp_lane_prefix #(
    parameter int NRET  = 2,
    parameter int CNT_W = $clog2(NRET) + 1
) (
    input  logic [NRET-1:0]            rvfi_valid,
    output logic [NRET-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]           total
);

    logic [CNT_W-1:0] acc_s;

    // Running count of valid lanes below each lane.
    always_comb begin
        acc_s  = '0;
        offset = '0;
        for (int i = 0; i < NRET; i++) begin
            offset[i] = acc_s;
            acc_s     = acc_s + CNT_W'(rvfi_valid[i]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/psp_retire_monitor.sv
// Retire-order counter with first-error latch, end-of-test and no-retire watchdog verdict.
// Optional retire-width histogram is built when PSP_RETMON_STATS_EN is defined.
module psp_retire_monitor
    import psp_retmon_pkg::*;
#(
    parameter int NRET       = 2,
    parameter int ORDER_W    = 64,
    parameter int ERR_W      = 16,
    parameter int TMO_W      = 20,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    input  logic [NRET-1:0]               rvfi_valid,
    input  logic [NRET-1:0][ERR_W-1:0]    errcode,
    input  logic                          done,
    output logic [NRET-1:0][ORDER_W-1:0]  lane_order,
    output logic [ORDER_W-1:0]            order,
    output logic [1:0]                    state,
    output logic [ERR_W-1:0]              err_code,
    output logic [ORDER_W-1:0]            err_order,
    output logic [$clog2(NRET):0]         err_lane,
    output logic                          finished,
`ifdef PSP_RETMON_STATS_EN
    output logic [NRET:0][31:0]           retire_hist,
`endif
    output logic                          pass
);

    localparam int CNT_W  = $clog2(NRET) + 1;
    localparam int LANE_W = $clog2(NRET) + 1;

    retmon_state_e              state_r, state_nxt;
    logic [ORDER_W-1:0]         order_r, order_nxt;
    logic [ERR_W-1:0]           err_code_r, err_code_nxt;
    logic [ORDER_W-1:0]         err_order_r, err_order_nxt;
    logic [LANE_W-1:0]          err_lane_r, err_lane_nxt;
    logic [TMO_W-1:0]           wd_r, wd_nxt;
    logic                       finished_r, pass_r;

    logic [NRET-1:0][CNT_W-1:0] offset_s;
    logic [CNT_W-1:0]           total_s;
    logic                       any_valid_s, timeout_s;
    logic                       lane_err_s, err_hit_s;
    logic [LANE_W-1:0]          err_lane_s;
    logic [ERR_W-1:0]           err_code_s;
    logic [ORDER_W-1:0]         err_order_s;

    psp_lane_prefix #(.NRET(NRET), .CNT_W(CNT_W)) u_prefix (
        .rvfi_valid (rvfi_valid),
        .offset     (offset_s),
        .total      (total_s)
    );

    assign any_valid_s = |rvfi_valid;
    assign timeout_s   = !any_valid_s && (wd_r == TMO_W'(TMO_CYCLES - 1));

    // Per-lane order numbers relative to the current committed count.
    always_comb begin
        lane_order = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_order[i] = order_r + ORDER_W'(offset_s[i]);
        end
    end

    // Lowest erring lane wins: scan high to low so lower lanes overwrite.
    always_comb begin
        lane_err_s  = 1'b0;
        err_hit_s   = 1'b0;
        err_lane_s  = '0;
        err_code_s  = '0;
        err_order_s = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            lane_err_s  = rvfi_valid[i] && (errcode[i] != '0);
            err_hit_s   = err_hit_s | lane_err_s;
            err_lane_s  = lane_err_s ? LANE_W'(i) : err_lane_s;
            err_code_s  = lane_err_s ? errcode[i] : err_code_s;
            err_order_s = lane_err_s ? lane_order[i] : err_order_s;
        end
    end

    // Next-state and next-register values; terminal states hold everything.
    always_comb begin
        state_nxt     = state_r;
        order_nxt     = order_r;
        err_code_nxt  = err_code_r;
        err_order_nxt = err_order_r;
        err_lane_nxt  = err_lane_r;
        wd_nxt        = wd_r;
        if (clr) begin
            state_nxt     = ST_RUN;
            order_nxt     = '0;
            err_code_nxt  = '0;
            err_order_nxt = '0;
            err_lane_nxt  = '0;
            wd_nxt        = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    order_nxt = order_r + ORDER_W'(total_s);
                    wd_nxt    = any_valid_s ? '0 : wd_r + TMO_W'(1);
                    if (err_hit_s) begin
                        state_nxt     = ST_FAIL;
                        err_code_nxt  = err_code_s;
                        err_order_nxt = err_order_s;
                        err_lane_nxt  = err_lane_s;
                    end else if (done) begin
                        state_nxt = ST_PASS;
                    end else if (timeout_s) begin
                        state_nxt = ST_TIMEOUT;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = state_r;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            order_r     <= '0;
            err_code_r  <= '0;
            err_order_r <= '0;
            err_lane_r  <= '0;
            wd_r        <= '0;
            finished_r  <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            order_r     <= order_nxt;
            err_code_r  <= err_code_nxt;
            err_order_r <= err_order_nxt;
            err_lane_r  <= err_lane_nxt;
            wd_r        <= wd_nxt;
            finished_r  <= (state_nxt != ST_RUN);
            pass_r      <= (state_nxt == ST_PASS);
        end
    end

    assign state     = state_r;
    assign order     = order_r;
    assign err_code  = err_code_r;
    assign err_order = err_order_r;
    assign err_lane  = err_lane_r;
    assign finished  = finished_r;
    assign pass      = pass_r;

`ifdef PSP_RETMON_STATS_EN
    logic [NRET:0][31:0] hist_r;

    // Saturating count of RUN cycles per retire width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
        end else if (state_r == ST_RUN) begin
            for (int k = 0; k <= NRET; k++) begin
                if ((total_s == CNT_W'(k)) && (hist_r[k] != 32'hFFFF_FFFF)) begin
                    hist_r[k] <= hist_r[k] + 32'd1;
                end
            end
        end
    end

    assign retire_hist = hist_r;
`endif

endmodule
